// File: rtl/uart_rx_deser_pkg.sv
// Shared UART definitions: receiver state encoding, frame size and baud divider helper.
package uart_rx_deser_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MIN_BAUD_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Clocks per bit, truncated.
    function automatic int unsigned calc_baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones (line idle / mark).
module uart_rx_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronises rxd, samples mid-bit, presents the byte with a 1-cycle strobe.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

    generate
        if (BAUD_DIV < MIN_BAUD_DIV) begin : g_div_check
            $error("uart_rx_deser: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    rx_state_e            state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 frame_err_nxt;
    logic                 rxd_s;
    logic                 rxd_q;
    logic                 start_edge_c;
    logic                 cnt_zero_c;

    uart_rx_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (rxd),
        .q      (rxd_s)
    );

    assign start_edge_c = rxd_q & ~rxd_s;
    assign cnt_zero_c   = (bit_cnt == '0);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_edge_c) begin
                    bit_cnt_nxt = HALF_RELOAD;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (!cnt_zero_c) begin
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                end else if (!rxd_s) begin
                    bit_cnt_nxt = BIT_RELOAD;
                    bit_idx_nxt = '0;
                    state_nxt   = ST_DATA;
                end else begin
                    state_nxt   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!cnt_zero_c) begin
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                end else begin
                    shreg_nxt   = {rxd_s, shreg[DATA_BITS-1:1]};
                    bit_cnt_nxt = BIT_RELOAD;
                    bit_idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (!cnt_zero_c) begin
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                end else if (rxd_s) begin
                    rx_data_nxt  = shreg;
                    rx_valid_nxt = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Line held low: no new start accepted until it returns to mark.
                if (rxd_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rxd_q     <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            rxd_q     <= rxd_s;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
            rx_busy   <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 16 clocks per bit: frame table plus glitch, break and reset cases.
module tb_uart_rx_deser;

    localparam int unsigned BIT_CLKS = 16;
    localparam longint      CLK_NS   = 10;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned gap;
        int unsigned exp_valid;
        int unsigned exp_err;
        logic [7:0]  exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int     checks = 0;
    int     errors = 0;
    int     n_valid = 0;
    int     n_err = 0;
    int     n_dbl = 0;
    int     n_both = 0;
    logic   prev_valid = 1'b0;
    logic [7:0] last_data = 8'h00;
    longint t_start = 0;
    longint t_valid = 0;

    uart_rx_deser #(
        .CLK_HZ(1600),
        .BAUD  (100)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            last_data = rx_data;
            t_valid = $time;
            if (prev_valid) n_dbl++;
        end
        if (frame_err) n_err++;
        if (rx_valid && frame_err) n_both++;
        prev_valid = rx_valid;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        t_start = $time;
        idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(BIT_CLKS);
        end
        rxd = stop;
        idle(BIT_CLKS);
    endtask

    vec_t vecs[6];

    initial begin
        int v0;
        int e0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 30, exp_valid: 1, exp_err: 0, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop: 1'b1, gap: 0,  exp_valid: 1, exp_err: 0, exp_data: 8'h3C};
        vecs[2] = '{data: 8'hC3, stop: 1'b1, gap: 30, exp_valid: 1, exp_err: 0, exp_data: 8'hC3};
        vecs[3] = '{data: 8'h00, stop: 1'b1, gap: 5,  exp_valid: 1, exp_err: 0, exp_data: 8'h00};
        vecs[4] = '{data: 8'hFF, stop: 1'b1, gap: 30, exp_valid: 1, exp_err: 0, exp_data: 8'hFF};
        vecs[5] = '{data: 8'h5A, stop: 1'b1, gap: 30, exp_valid: 1, exp_err: 0, exp_data: 8'h5A};

        // Reset values
        idle(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_rx_busy", rx_busy, 0);
        reset_n = 1'b1;

        // Idle line after reset
        v0 = n_valid;
        idle(200);
        check("idle_busy", rx_busy, 0);
        check("idle_valid_cnt", n_valid - v0, 0);
        check("idle_rx_data", rx_data, 8'h00);

        // Frame table, including a back-to-back pair
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("vec%0d_valid_cnt", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_err_cnt", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_last_data", i), last_data, vecs[i].exp_data);
            if (vecs[i].exp_valid != 0)
                check_range($sformatf("vec%0d_latency", i), (t_valid - t_start) / CLK_NS, 153, 155);
            idle(vecs[i].gap);
        end

        // Short low glitch aborts in START
        v0 = n_valid;
        e0 = n_err;
        rxd = 1'b0;
        idle(4);
        check("glitch_busy_during", rx_busy, 1);
        rxd = 1'b1;
        idle(40);
        check("glitch_valid_cnt", n_valid - v0, 0);
        check("glitch_err_cnt", n_err - e0, 0);
        check("glitch_busy_after", rx_busy, 0);

        // Bad stop bit followed by a held-low line
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h55, 1'b0);
        idle(40);
        check("break_err_cnt", n_err - e0, 1);
        check("break_valid_cnt", n_valid - v0, 0);
        check("break_rx_data", rx_data, 8'h5A);
        check("break_busy_low", rx_busy, 1);
        rxd = 1'b1;
        idle(10);
        check("break_busy_released", rx_busy, 0);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h0F, 1'b1);
        idle(30);
        check("after_break_valid_cnt", n_valid - v0, 1);
        check("after_break_err_cnt", n_err - e0, 0);
        check("after_break_rx_data", rx_data, 8'h0F);

        // Reset in the middle of the data bits
        v0 = n_valid;
        rxd = 1'b0;
        idle(BIT_CLKS);
        rxd = 1'b1;
        idle(3 * BIT_CLKS);
        check("mid_frame_busy", rx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_rx_data", rx_data, 8'h00);
        check("async_reset_busy", rx_busy, 0);
        check("async_reset_valid", rx_valid, 0);
        idle(5);
        reset_n = 1'b1;
        idle(200);
        check("post_reset_no_strobe", n_valid - v0, 0);
        send_frame(8'h81, 1'b1);
        idle(30);
        check("post_reset_valid_cnt", n_valid - v0, 1);
        check("post_reset_rx_data", rx_data, 8'h81);

        // Global strobe properties
        check("valid_consecutive", n_dbl, 0);
        check("valid_err_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
